// File: rtl/modp_accumulator.sv
// Streaming mod-P accumulator: sums valid/ready residue terms into one result per block.
// Optional range check on incoming terms is enabled by defining MODP_ACC_RANGE_CHK_EN.
module modp_accumulator #(
  parameter int P       = 1621,
  parameter int W       = 11,
  parameter int N_TERMS = 16,
  localparam int CW     = $clog2(N_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  din_r,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  dout_sum,
  output logic [CW-1:0] dout_cnt,
  output logic          err
);

  localparam logic [W:0]    P_W1  = (W + 1)'(P);
  localparam logic [CW-1:0] N_CW  = CW'(N_TERMS);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_sum;
  logic [CW-1:0] r_cnt_out;

  logic          w_xfer;
  logic          w_release;
  logic          w_term;
  logic [W:0]    w_s;
  logic [W-1:0]  w_red;
  logic [W-1:0]  w_acc_next;
  logic [CW-1:0] w_cnt_inc;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign dout_sum  = r_sum;
  assign dout_cnt  = r_cnt_out;

  assign w_xfer    = in_valid && in_ready;
  assign w_release = out_valid && out_ready;

  // Both operands are below 2**W, so one conditional subtract suffices for in-range terms.
  assign w_s       = {1'b0, r_acc} + {1'b0, din_r};
  assign w_red     = (w_s >= P_W1) ? W'(w_s - P_W1) : W'(w_s);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_term    = in_last || (w_cnt_inc == N_CW);

`ifdef MODP_ACC_RANGE_CHK_EN
  logic w_oor;
  logic r_err;

  // Out-of-range terms still count toward the block but leave the sum untouched.
  assign w_oor      = ({1'b0, din_r} >= P_W1);
  assign w_acc_next = w_oor ? r_acc : w_red;
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_xfer && w_oor) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_acc_next = w_red;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_xfer && w_term) w_state_next = DONE;
      DONE:    if (out_ready)        w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_cnt_out <= '0;
    end else if (w_xfer) begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_inc;
      if (w_term) begin
        r_sum     <= w_acc_next;
        r_cnt_out <= w_cnt_inc;
      end
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_modp_accumulator.sv
// Directed and back-to-back random checks for modp_accumulator (P=1621, N_TERMS=16).
module tb_modp_accumulator;

  localparam int P  = 1621;
  localparam int W  = 11;
  localparam int NT = 16;
  localparam int CW = $clog2(NT + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  din_r;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout_sum;
  logic [CW-1:0] dout_cnt;
  logic          err;

  int n_vec = 0;
  int n_err = 0;

  modp_accumulator #(.P(P), .W(W), .N_TERMS(NT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .din_r(din_r), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout_sum(dout_sum), .dout_cnt(dout_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one term and hold it until it transfers (bounded).
  task automatic send(input int d, input logic last);
    bit done = 0;
    in_valid = 1'b1;
    din_r    = W'(d);
    in_last  = last;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: observed in_ready 0 expected 1");
    end
  endtask

  // Consume the pending result with a one-cycle out_ready pulse.
  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  int         cyc, got, k, len, msum, cur_d, exp_sum, exp_cnt;
  bit         pend, nxt_pend, lastflag;
  logic [W-1:0]  hold_sum;
  logic [CW-1:0] hold_cnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; din_r = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dout_sum", dout_sum, 0);
    check("rst_dout_cnt", dout_cnt, 0);
    check("rst_err", err, 0);

    // Wrap to zero: 1620 + 1 == P
    send(1620, 1'b0);
    check("wrap_mid_out_valid", out_valid, 0);
    send(1, 1'b1);
    check("wrap_out_valid", out_valid, 1);
    check("wrap_in_ready", in_ready, 0);
    check("wrap_sum", dout_sum, 0);
    check("wrap_cnt", dout_cnt, 2);
    release_result();
    check("wrap_in_ready_back", in_ready, 1);
    check("wrap_out_valid_low", out_valid, 0);

    // Full block terminated by count: 16*1000 mod 1621 = 1411
    for (int i = 0; i < 16; i++) send(1000, 1'b0);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_sum", dout_sum, 1411);
    check("full_cnt", dout_cnt, 16);

    // Backpressure with a producer pushing the whole time
    in_valid = 1'b1; din_r = W'(5); in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sum", dout_sum, 1411);
      check("bp_cnt", dout_cnt, 16);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_result();
    check("bp_in_ready_back", in_ready, 1);
    send(3, 1'b1);
    check("bp_next_sum", dout_sum, 3);
    check("bp_next_cnt", dout_cnt, 1);
    release_result();

    // Reset mid-block discards partial sum
    send(7, 1'b0); send(9, 1'b0); send(11, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_dout_cnt", dout_cnt, 0);
    send(5, 1'b0); send(6, 1'b1);
    check("mrst_out_valid_done", out_valid, 1);
    check("mrst_sum", dout_sum, 11);
    check("mrst_cnt", dout_cnt, 2);
    release_result();

    // Out-of-range term
    send(1700, 1'b1);
    check("range_out_valid", out_valid, 1);
    check("range_cnt", dout_cnt, 1);
`ifdef MODP_ACC_RANGE_CHK_EN
    check("range_err", err, 1);
    check("range_sum", dout_sum, 0);
`else
    check("range_err", err, 0);
    check("range_sum", dout_sum, 79);
`endif
    // Reset while DONE drops the result and clears err
    rst = 1'b1; tick(); rst = 1'b0;
    check("drst_out_valid", out_valid, 0);
    check("drst_in_ready", in_ready, 1);
    check("drst_err", err, 0);
    check("drst_sum", dout_sum, 0);

    // Back-to-back random blocks, out_ready and in_valid held high
    hold_sum = '0; hold_cnt = '0;
    cyc = 0; got = 0; k = 0; msum = 0; pend = 0; exp_sum = 0; exp_cnt = 0;
    len = $urandom_range(1, NT);
    lastflag = 1'($urandom_range(0, 1));
    cur_d = $urandom_range(0, P - 1);
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 1000 && cyc < 40000) begin
      din_r   = W'(cur_d);
      in_last = (k == len - 1) && (len < NT || lastflag);
      check("b2b_out_valid", out_valid, pend);
      check("b2b_in_ready", in_ready, !pend);
      nxt_pend = 0;
      if (pend) begin
        check("b2b_sum", dout_sum, exp_sum);
        check("b2b_cnt", dout_cnt, exp_cnt);
        got++;
      end else begin
        msum = (msum + cur_d) % P;
        k++;
        if (k == len) begin
          exp_sum = msum;
          exp_cnt = len;
          nxt_pend = 1;
          msum = 0;
          k = 0;
          len = $urandom_range(1, NT);
          lastflag = 1'($urandom_range(0, 1));
        end
        cur_d = $urandom_range(0, P - 1);
      end
      tick();
      cyc++;
      pend = nxt_pend;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_blocks_done", got, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
